// File: rtl/pio_in_edge.sv
// Input PIO slave: samples in_port, latches per-bit edges into a sticky W1C capture register, raises irq on unmasked captures.
// Define PIO_IN_SYNC_EN to put a two-flop synchronizer in front of the data register.

module pio_in_edge_bit #(
  parameter int EDGE_TYPE = 0
) (
  input  logic cur,
  input  logic prev,
  input  logic cap,
  input  logic clr,
  output logic cap_nxt
);
  logic ev;

  always_comb begin
    ev = 1'b0;
    case (EDGE_TYPE)
      0:       ev = cur & ~prev;
      1:       ev = ~cur & prev;
      default: ev = cur ^ prev;
    endcase
    // A new edge beats a clear landing in the same cycle.
    cap_nxt = (cap & ~clr) | ev;
  end
endmodule

module pio_in_edge #(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_CAP  = 2'd3;

  logic             wr_en;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] data_in_d,   data_in_q;
  logic [WIDTH-1:0] data_prev_d, data_prev_q;
  logic [WIDTH-1:0] mask_d,      mask_q;
  logic [WIDTH-1:0] cap_d,       cap_q;
  logic             unused_wd;

  assign unused_wd = ^writedata;

`ifdef PIO_IN_SYNC_EN
  logic [WIDTH-1:0] sync_d, sync_q;

  assign sync_d = in_port;

  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;

  assign data_in_d = sync_q;
`else
  assign data_in_d = in_port;
`endif

  always_comb begin
    wr_en       = chipselect & ~write_n;
    data_prev_d = data_in_q;
    mask_d      = mask_q;
    clr         = '0;
    if (wr_en && address == A_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == A_CAP)  clr    = writedata[WIDTH-1:0];
  end

  pio_in_edge_bit #(.EDGE_TYPE(EDGE_TYPE)) u_bit [WIDTH-1:0] (
    .cur     (data_in_q),
    .prev    (data_prev_q),
    .cap     (cap_q),
    .clr     (clr),
    .cap_nxt (cap_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_in_q   <= '0;
      data_prev_q <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
    end else begin
      data_in_q   <= data_in_d;
      data_prev_q <= data_prev_d;
      mask_q      <= mask_d;
      cap_q       <= cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:  readdata[WIDTH-1:0] = data_in_q;
      A_MASK:  readdata[WIDTH-1:0] = mask_q;
      A_CAP:   readdata[WIDTH-1:0] = cap_q;
      default: readdata = '0;
    endcase
    irq = |(cap_q & mask_q);
  end
endmodule
